// File: rtl/i2s_delay_sum_beamformer.sv
// Delay-and-sum beamformer on I2S: deserialises NUM_MICS/2 stereo lines,
// delays each mic by a programmable number of frames, averages the delayed
// samples and serialises the mono result into both slots of the next frame.
module i2s_delay_sum_beamformer #(
  parameter int NUM_MICS    = 4,
  parameter int SAMPLE_BITS = 16,
  parameter int SLOT_BITS   = 32,
  parameter int BUFFER_SIZE = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_MICS/2-1:0]       sd_in,
  output logic                        ws_out,
  output logic                        sd_out,
  output logic                        frame_strobe,
  input  logic                        cfg_we,
  input  logic [$clog2(NUM_MICS)-1:0] cfg_sel,
  input  logic [7:0]                  cfg_delay
);
  localparam int LINES = NUM_MICS / 2;
  localparam int MIC_W = $clog2(NUM_MICS);
  localparam int FC_W  = $clog2(2 * SLOT_BITS);
  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int SUM_W = SAMPLE_BITS + MIC_W;
  localparam logic [FC_W-1:0] SLOT_FC = FC_W'(SLOT_BITS);
  localparam logic [FC_W-1:0] LAST_FC = FC_W'(2 * SLOT_BITS - 1);
  localparam logic [FC_W-1:0] SAMP_FC = FC_W'(SAMPLE_BITS);
  localparam logic [7:0]      MAX_DLY = 8'(BUFFER_SIZE - 1);

  // Requested delays beyond the ring depth clamp to the oldest entry.
  function automatic logic [PTR_W-1:0] sat_delay(input logic [7:0] req);
    if (req > MAX_DLY) return PTR_W'(BUFFER_SIZE - 1);
    return req[PTR_W-1:0];
  endfunction

  // Floor average: arithmetic shift of the exact sum by log2(NUM_MICS).
  function automatic logic signed [SAMPLE_BITS-1:0] avg_floor(input logic signed [SUM_W-1:0] sum);
    return SAMPLE_BITS'(sum >>> MIC_W);
  endfunction

  // Bit position within the current slot (left and right slots look alike).
  function automatic logic [FC_W-1:0] slot_off(input logic [FC_W-1:0] fc);
    return (fc >= SLOT_FC) ? fc - SLOT_FC : fc;
  endfunction

  logic [FC_W-1:0]               fc_q, fc_d;
  logic                          ws_out_q, ws_out_d;
  logic                          frame_strobe_q, frame_strobe_d;
  logic                          sd_out_q, sd_out_d;
  logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]              shadow_q [NUM_MICS];
  logic [PTR_W-1:0]              shadow_d [NUM_MICS];
  logic [PTR_W-1:0]              active_q [NUM_MICS];
  logic [PTR_W-1:0]              active_d [NUM_MICS];
  logic signed [SAMPLE_BITS-1:0] shift_q  [NUM_MICS];
  logic signed [SAMPLE_BITS-1:0] shift_d  [NUM_MICS];
  logic signed [SAMPLE_BITS-1:0] ring_q   [BUFFER_SIZE][NUM_MICS];
  logic signed [SAMPLE_BITS-1:0] ring_d   [BUFFER_SIZE][NUM_MICS];
  logic signed [SAMPLE_BITS-1:0] out_word_q, out_word_d;
  logic                          boundary;
  logic                          capture;
  logic [FC_W-1:0]               s_cur, s_next;

  // Frame counter, word select and end-of-frame strobe, aligned to fc_q.
  always_comb begin
    boundary       = (fc_q == LAST_FC);
    fc_d           = boundary ? '0 : fc_q + 1'b1;
    ws_out_d       = (fc_d >= SLOT_FC);
    frame_strobe_d = (fc_d == LAST_FC);
    s_cur          = slot_off(fc_q);
    s_next         = slot_off(fc_d);
    capture        = (s_cur != '0) && (s_cur <= SAMP_FC);
  end

  // Shift sample bits in MSB first; the slot decides which mic of a line.
  always_comb begin
    shift_d = shift_q;
    if (capture) begin
      for (int k = 0; k < LINES; k++) begin
        if (fc_q >= SLOT_FC)
          shift_d[2*k+1] = {shift_q[2*k+1][SAMPLE_BITS-2:0], sd_in[k]};
        else
          shift_d[2*k] = {shift_q[2*k][SAMPLE_BITS-2:0], sd_in[k]};
      end
    end
  end

  // Shadow delays take writes any cycle; active copies follow only at a boundary.
  always_comb begin
    shadow_d = shadow_q;
    if (boundary) active_d = shadow_q;
    else          active_d = active_q;
    if (cfg_we) shadow_d[cfg_sel] = sat_delay(cfg_delay);
  end

  // At the boundary push the frame into the ring and form the delayed average.
  always_comb begin
    logic signed [SUM_W-1:0]       sum;
    logic [PTR_W-1:0]              rd_idx;
    logic signed [SAMPLE_BITS-1:0] tap;
    ring_d     = ring_q;
    wr_ptr_d   = wr_ptr_q;
    out_word_d = out_word_q;
    sum        = '0;
    rd_idx     = '0;
    tap        = '0;
    if (boundary) begin
      for (int m = 0; m < NUM_MICS; m++) begin
        ring_d[wr_ptr_q][m] = shift_q[m];
        rd_idx = wr_ptr_q - active_d[m];
        tap    = (active_d[m] == '0) ? shift_q[m] : ring_q[rd_idx][m];
        sum    = sum + {{MIC_W{tap[SAMPLE_BITS-1]}}, tap};
      end
      wr_ptr_d   = wr_ptr_q + 1'b1;
      out_word_d = avg_floor(sum);
    end
  end

  // Serialise the held word MSB first from slot offset 1; silence elsewhere.
  always_comb begin
    sd_out_d = 1'b0;
    if ((s_next != '0) && (s_next <= SAMP_FC))
      sd_out_d = |(out_word_q & (SAMPLE_BITS'(1) << (SAMP_FC - s_next)));
  end

  // State registers; reset aborts any frame in progress and clears all history.
  always_ff @(posedge clk) begin
    if (reset) begin
      fc_q           <= '0;
      ws_out_q       <= 1'b0;
      frame_strobe_q <= 1'b0;
      sd_out_q       <= 1'b0;
      wr_ptr_q       <= '0;
      out_word_q     <= '0;
      for (int m = 0; m < NUM_MICS; m++) begin
        shadow_q[m] <= '0;
        active_q[m] <= '0;
        shift_q[m]  <= '0;
        for (int b = 0; b < BUFFER_SIZE; b++) ring_q[b][m] <= '0;
      end
    end else begin
      fc_q           <= fc_d;
      ws_out_q       <= ws_out_d;
      frame_strobe_q <= frame_strobe_d;
      sd_out_q       <= sd_out_d;
      wr_ptr_q       <= wr_ptr_d;
      out_word_q     <= out_word_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      shift_q        <= shift_d;
      ring_q         <= ring_d;
    end
  end

  assign ws_out       = ws_out_q;
  assign sd_out       = sd_out_q;
  assign frame_strobe = frame_strobe_q;

endmodule

// File: tb/tb_i2s_delay_sum_beamformer.sv
// Bench for the I2S delay-and-sum beamformer: frame-level reference model
// with a sample history per frame and floor-division averaging.
module tb_i2s_delay_sum_beamformer;
  localparam int NM   = 4;
  localparam int SB   = 16;
  localparam int SL   = 32;
  localparam int BS   = 8;
  localparam int FL   = 2 * SL;
  localparam int MAXF = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic [NM/2-1:0] sd_in;
  logic          ws_out, sd_out, frame_strobe;
  logic          cfg_we;
  logic [1:0]    cfg_sel;
  logic [7:0]    cfg_delay;

  i2s_delay_sum_beamformer #(
    .NUM_MICS(NM), .SAMPLE_BITS(SB), .SLOT_BITS(SL), .BUFFER_SIZE(BS)
  ) dut (
    .clk(clk), .reset(reset), .sd_in(sd_in), .ws_out(ws_out), .sd_out(sd_out),
    .frame_strobe(frame_strobe), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_delay(cfg_delay)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic signed [SB-1:0] hist [MAXF][NM];
  logic signed [SB-1:0] cur  [NM];
  int                   shadow_m [NM];
  int                   fidx;
  logic [SB-1:0]        exp_cur;
  logic [SB-1:0]        last_l, last_r;
  int                   wr_ph  [2] = '{-1, -1};
  int                   wr_mic [2] = '{0, 0};
  int                   wr_val [2] = '{0, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    fidx    = 0;
    exp_cur = '0;
    for (int m = 0; m < NM; m++) shadow_m[m] = 0;
  endtask

  // Output word for the next frame: mean (rounded toward -inf) of each mic's
  // sample from d frames ago; frames before the last reset count as zero.
  task automatic model_boundary();
    int sum, q, idx;
    sum = 0;
    for (int m = 0; m < NM; m++) hist[fidx][m] = cur[m];
    for (int m = 0; m < NM; m++) begin
      idx = fidx - shadow_m[m];
      if (idx >= 0) sum += int'(hist[idx][m]);
    end
    q = sum / NM;
    if ((sum % NM) != 0 && sum < 0) q = q - 1;
    exp_cur = q[SB-1:0];
    fidx++;
  endtask

  task automatic set_mics(input logic [SB-1:0] a, b, c, d);
    cur[0] = a; cur[1] = b; cur[2] = c; cur[3] = d;
  endtask

  task automatic rand_mics();
    for (int m = 0; m < NM; m++) cur[m] = 16'($urandom);
  endtask

  task automatic sched(input int j, input int ph, input int mic, input int val);
    wr_ph[j] = ph; wr_mic[j] = mic; wr_val[j] = val;
  endtask

  // One frame: drive cur[] onto the I2S lines, collect sd_out, check at the end.
  task automatic run_frame(input int rst_at);
    logic [SB-1:0] gl, gr;
    bit stray, ws_bad, fs_bad;
    int s;
    gl = '0; gr = '0; stray = 0; ws_bad = 0; fs_bad = 0;
    for (int ph = 0; ph < FL; ph++) begin
      if (ws_out !== (ph >= SL)) ws_bad = 1;
      if (frame_strobe !== (ph == FL - 1)) fs_bad = 1;
      s = (ph >= SL) ? ph - SL : ph;
      if (s >= 1 && s <= SB) begin
        if (ph < SL) gl[SB-s] = sd_out;
        else         gr[SB-s] = sd_out;
      end else if (sd_out !== 1'b0) begin
        stray = 1;
      end
      for (int k = 0; k < NM/2; k++) begin
        if (s >= 1 && s <= SB) sd_in[k] = cur[2*k + ((ph >= SL) ? 1 : 0)][SB-s];
        else                   sd_in[k] = 1'($urandom);
      end
      cfg_we = 1'b0; cfg_sel = '0; cfg_delay = '0;
      for (int j = 0; j < 2; j++) begin
        if (wr_ph[j] == ph) begin
          cfg_we = 1'b1; cfg_sel = wr_mic[j][1:0]; cfg_delay = wr_val[j][7:0];
        end
      end
      reset = (ph == rst_at);
      if (ph == FL - 1) begin
        check("sd_left_word", {16'h0, gl}, {16'h0, exp_cur});
        check("sd_right_word", {16'h0, gr}, {16'h0, exp_cur});
        check("sd_idle_zero", {31'h0, stray}, 32'h0);
        check("ws_pattern", {31'h0, ws_bad}, 32'h0);
        check("strobe_pattern", {31'h0, fs_bad}, 32'h0);
        last_l = gl; last_r = gr;
        model_boundary();
      end
      if (cfg_we) shadow_m[cfg_sel] = (cfg_delay > 8'(BS - 1)) ? BS - 1 : int'(cfg_delay);
      @(posedge clk); #1;
      if (reset) begin
        reset = 1'b0;
        check("rst_mid_ws", {31'h0, ws_out}, 32'h0);
        check("rst_mid_sd", {31'h0, sd_out}, 32'h0);
        check("rst_mid_strobe", {31'h0, frame_strobe}, 32'h0);
        model_reset();
        break;
      end
    end
    cfg_we = 1'b0;
    wr_ph[0] = -1; wr_ph[1] = -1;
  endtask

  initial begin
    reset = 1'b1; sd_in = '0; cfg_we = 1'b0; cfg_sel = '0; cfg_delay = '0;
    set_mics(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_ws", {31'h0, ws_out}, 32'h0);
    check("reset_sd", {31'h0, sd_out}, 32'h0);
    check("reset_strobe", {31'h0, frame_strobe}, 32'h0);
    reset = 1'b0;
    model_reset();

    // Quiet start: two frames of silence, timing pattern checked each frame
    run_frame(-1);
    run_frame(-1);

    // Plain average, then the extreme-value cases
    set_mics(16'h1000, 16'h2000, 16'h3000, 16'h4000); run_frame(-1);
    set_mics(16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000); run_frame(-1);
    check("avg_basic_2800", {16'h0, last_l}, 32'h2800);
    set_mics(16'h8000, 16'h8000, 16'h8000, 16'h8000); run_frame(-1);
    check("avg_floor_ffff", {16'h0, last_l}, 32'hFFFF);
    set_mics(0, 0, 0, 0); run_frame(-1);
    check("avg_all_min_8000", {16'h0, last_r}, 32'h8000);

    // Impulse through a 3-frame delay on mic0
    sched(0, 10, 0, 3);
    run_frame(-1); run_frame(-1); run_frame(-1);
    set_mics(16'h4000, 0, 0, 0); run_frame(-1);
    set_mics(0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      run_frame(-1);
      if (i == 3) check("impulse_early_zero", {16'h0, last_l}, 32'h0);
      if (i == 4) check("impulse_at_k4", {16'h0, last_l}, 32'h1000);
      if (i == 5) check("impulse_after_zero", {16'h0, last_r}, 32'h0);
    end

    // Saturating delay request on mic1, random data
    sched(0, 7, 1, 9);
    rand_mics(); run_frame(-1);
    for (int i = 0; i < 8; i++) begin rand_mics(); run_frame(-1); end
    // Write landing in the boundary cycle itself
    sched(0, FL - 1, 1, 2);
    rand_mics(); run_frame(-1);
    rand_mics(); run_frame(-1);
    rand_mics(); run_frame(-1);
    // Two writes to one mic in the same frame: the later one holds
    sched(0, 5, 2, 6);
    sched(1, 40, 2, 1);
    rand_mics(); run_frame(-1);
    for (int i = 0; i < 3; i++) begin rand_mics(); run_frame(-1); end

    // Random reprogramming with random data
    for (int i = 0; i < 10; i++) begin
      sched(0, $urandom_range(0, FL - 1), $urandom_range(0, NM - 1), $urandom_range(0, 12));
      rand_mics(); run_frame(-1);
    end

    // Mid-frame reset with data in flight, then mic2 at the deepest delay
    sched(0, 3, 2, 7);
    rand_mics(); run_frame(-1);
    rand_mics(); run_frame(-1);
    rand_mics(); run_frame(20);
    sched(0, 2, 2, 7);
    for (int i = 0; i < 11; i++) begin rand_mics(); run_frame(-1); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
